// File: rtl/pio_cfg_arbiter.sv
// Round-robin arbiter sharing the PIO host command port among NREQ requesters,
// with lockable atomic bursts, lock timeout and in-order read-data return.
module pio_cfg_arbiter #(
  parameter int NREQ     = 4,
  parameter int RD_LAT   = 1,
  parameter int MAX_LOCK = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    lock,
  input  logic [4*NREQ-1:0]  req_action,
  input  logic [2*NREQ-1:0]  req_mindex,
  input  logic [5*NREQ-1:0]  req_index,
  input  logic [32*NREQ-1:0] req_din,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [31:0]        rdata,
  output logic [NREQ-1:0]    lock_err,
  output logic [3:0]         pio_action,
  output logic [1:0]         pio_mindex,
  output logic [4:0]         pio_index,
  output logic [31:0]        pio_din,
  input  logic [31:0]        pio_dout
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_LOCK + 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr, owner, blk_id;
  logic            blk_vld;
  logic [CW-1:0]   lock_cnt;

  logic            hold, tmo, lock_take;
  logic            win_vld, gnt_vld;
  logic [IW-1:0]   win_id, gnt_id;
  logic [IW:0]     cand;
  logic [3:0]      sel_action;
  logic            is_pull;

  logic [RD_LAT:0] rd_vld;
  logic [IW-1:0]   rd_id [RD_LAT+1];

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] id);
    return {{(NREQ-1){1'b0}}, 1'b1} << id;
  endfunction

  function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] id);
    return (id == IW'(NREQ - 1)) ? '0 : id + IW'(1);
  endfunction

  // The owner keeps the port only while it still asserts lock.
  assign hold = (state == LOCKED) && lock[owner];
  assign tmo  = hold && (lock_cnt == CW'(MAX_LOCK - 1));

  // Scan offsets from far to near so the requester closest to rr_ptr wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    win_vld = 1'b0;
    win_id  = '0;
    cand    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
      if (req[cand[IW-1:0]]) begin
        win_vld = 1'b1;
        win_id  = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    gnt_vld = hold ? req[owner] : win_vld;
    gnt_id  = hold ? owner : win_id;
    if (reset) gnt_vld = 1'b0;
  end

  assign gnt        = gnt_vld ? onehot(gnt_id) : '0;
  assign sel_action = req_action[4*gnt_id +: 4];
  assign is_pull    = gnt_vld && (sel_action == 4'd3);
  // A timed-out owner cannot re-lock until it has dropped lock once.
  assign lock_take  = !hold && gnt_vld && lock[gnt_id] && !(blk_vld && (blk_id == gnt_id));

  always_comb begin
    state_nxt = IDLE;
    if (hold)           state_nxt = tmo ? IDLE : LOCKED;
    else if (lock_take) state_nxt = LOCKED;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      lock_cnt   <= '0;
      blk_vld    <= 1'b0;
      blk_id     <= '0;
      lock_err   <= '0;
      rvalid     <= '0;
      rdata      <= '0;
      pio_action <= '0;
      pio_mindex <= '0;
      pio_index  <= '0;
      pio_din    <= '0;
    end else begin
      state <= state_nxt;
      if (gnt_vld) rr_ptr <= ptr_inc(gnt_id);

      if (lock_take) begin
        owner    <= gnt_id;
        lock_cnt <= CW'(1);
      end else if (hold) begin
        lock_cnt <= tmo ? '0 : lock_cnt + CW'(1);
      end else begin
        lock_cnt <= '0;
      end

      lock_err <= tmo ? onehot(owner) : '0;
      if (tmo) begin
        blk_vld <= 1'b1;
        blk_id  <= owner;
      end else if (blk_vld && !lock[blk_id]) begin
        blk_vld <= 1'b0;
      end

      pio_action <= gnt_vld ? sel_action : 4'd0;
      if (gnt_vld) begin
        pio_mindex <= req_mindex[2*gnt_id +: 2];
        pio_index  <= req_index[5*gnt_id +: 5];
        pio_din    <= req_din[32*gnt_id +: 32];
      end

      rvalid <= rd_vld[RD_LAT] ? onehot(rd_id[RD_LAT]) : '0;
      rdata  <= rd_vld[RD_LAT] ? pio_dout : 32'd0;
    end
  end

  // Read-return pipe: stage RD_LAT lines up with pio_dout for the issued pull.
  always_ff @(posedge clk) begin
    if (reset) rd_vld <= '0;
    else       rd_vld <= {rd_vld[RD_LAT-1:0], is_pull};
  end

  // NOTE: the id payload is qualified by rd_vld, so it needs no reset.
  always_ff @(posedge clk) begin
    rd_id[0] <= gnt_id;
    for (int s = 1; s <= RD_LAT; s++) rd_id[s] <= rd_id[s-1];
  end

endmodule

// File: tb/tb_pio_cfg_arbiter.sv
// Directed bench for pio_cfg_arbiter: reset, round robin, locked burst,
// read return with scoreboard, reset with pulls in flight, lock timeout.
module tb_pio_cfg_arbiter;

  localparam int NREQ   = 4;
  localparam int RD_LAT = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    req, lock;
  logic [15:0]   req_action;
  logic [7:0]    req_mindex;
  logic [19:0]   req_index;
  logic [127:0]  req_din;
  logic [31:0]   pio_dout;

  logic [3:0]    gnt, rvalid, lock_err, pio_action;
  logic [31:0]   rdata, pio_din;
  logic [1:0]    pio_mindex;
  logic [4:0]    pio_index;

  logic [3:0]    gnt_to, rvalid_to, lock_err_to, pio_action_to;
  logic [31:0]   rdata_to, pio_din_to;
  logic [1:0]    pio_mindex_to;
  logic [4:0]    pio_index_to;

  pio_cfg_arbiter #(.NREQ(NREQ), .RD_LAT(RD_LAT), .MAX_LOCK(256)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock),
    .req_action(req_action), .req_mindex(req_mindex), .req_index(req_index), .req_din(req_din),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .lock_err(lock_err),
    .pio_action(pio_action), .pio_mindex(pio_mindex), .pio_index(pio_index), .pio_din(pio_din),
    .pio_dout(pio_dout)
  );

  // Short-timeout instance, only checked in the lock-timeout sequence.
  pio_cfg_arbiter #(.NREQ(NREQ), .RD_LAT(RD_LAT), .MAX_LOCK(8)) dut_to (
    .clk(clk), .reset(reset), .req(req), .lock(lock),
    .req_action(req_action), .req_mindex(req_mindex), .req_index(req_index), .req_din(req_din),
    .gnt(gnt_to), .rvalid(rvalid_to), .rdata(rdata_to), .lock_err(lock_err_to),
    .pio_action(pio_action_to), .pio_mindex(pio_mindex_to), .pio_index(pio_index_to),
    .pio_din(pio_din_to), .pio_dout(pio_dout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          id;
    logic [31:0] data;
    int          due;
  } rd_exp_t;

  rd_exp_t sb[$];
  rd_exp_t mon_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // PIO model: a pull seen in cycle c returns 0xA0 + 0x11*index during cycle c+1.
  logic [31:0] dout_pend = 32'd0;
  always @(negedge clk)
    dout_pend = (pio_action == 4'd3) ? (32'hA0 + 32'h11 * {27'd0, pio_index}) : 32'hDEAD_BEEF;
  always @(posedge clk) begin
    #1;
    pio_dout = dout_pend;
  end

  // Scoreboard monitor: every rvalid must match the oldest expected return, on time.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && cyc > sb[0].due) begin
        check("rd_missing_cycle", 32'(cyc), 32'(sb[0].due));
        void'(sb.pop_front());
      end
      if (rvalid !== 4'b0000) begin
        if (sb.size() == 0) begin
          check("rd_spurious", {28'd0, rvalid}, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("rd_id", {28'd0, rvalid}, 32'(1 << mon_e.id));
          check("rd_data", rdata, mon_e.data);
          check("rd_cycle", 32'(cyc), 32'(mon_e.due));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_cmd(input int i, input logic [3:0] act, input logic [1:0] mi,
                         input logic [4:0] ix, input logic [31:0] d);
    req_action[4*i +: 4]  = act;
    req_mindex[2*i +: 2]  = mi;
    req_index[5*i +: 5]   = ix;
    req_din[32*i +: 32]   = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [3:0] rr_act [4];

  initial begin
    reset = 1'b1; req = '0; lock = '0;
    req_action = '0; req_mindex = '0; req_index = '0; req_din = '0;
    pio_dout = '0;
    rr_act = '{4'h1, 4'h5, 4'h2, 4'h0};

    repeat (3) step();
    sample();
    check("rst_gnt", {28'd0, gnt}, 32'd0);
    check("rst_rvalid", {28'd0, rvalid}, 32'd0);
    check("rst_pio_action", {28'd0, pio_action}, 32'd0);
    check("rst_pio_din", pio_din, 32'd0);
    step();
    reset = 1'b0;
    mon_en = 1'b1;

    // Idle after reset.
    for (int c = 0; c < 10; c++) begin
      sample();
      check("idle_pio_action", {28'd0, pio_action}, 32'd0);
      check("idle_gnt", {28'd0, gnt}, 32'd0);
      check("idle_rvalid", {28'd0, rvalid}, 32'd0);
      step();
    end

    // Round robin; requester 3 issues action 0 (NOP) which must still update pio_din.
    for (int i = 0; i < 4; i++) set_cmd(i, rr_act[i], 2'(i), 5'(i + 4), 32'h1000_0000 + 32'(i));
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      sample();
      check("rr_gnt", {28'd0, gnt}, 32'(1 << (k % 4)));
      if (k > 0) begin
        check("rr_pio_action", {28'd0, pio_action}, {28'd0, rr_act[(k - 1) % 4]});
        check("rr_pio_din", pio_din, 32'h1000_0000 + 32'((k - 1) % 4));
      end
      step();
    end
    req = 4'b0000;
    sample();
    check("rr_nop_action", {28'd0, pio_action}, 32'd0);
    check("rr_nop_din", pio_din, 32'h1000_0003);
    check("rr_nop_index", {27'd0, pio_index}, 32'd7);
    check("rr_idle_gnt", {28'd0, gnt}, 32'd0);
    step();
    sample();
    check("rr_hold_din", pio_din, 32'h1000_0003);
    check("rr_hold_action", {28'd0, pio_action}, 32'd0);
    step();

    // Locked burst by requester 2 while everyone else keeps requesting.
    for (int i = 0; i < 4; i++) set_cmd(i, 4'h2, 2'd0, 5'(i), 32'h2000 + 32'(i));
    req = 4'b0100;
    lock = 4'b0100;
    for (int j = 0; j < 32; j++) begin
      set_cmd(2, 4'h1, 2'd2, 5'(j), 32'(j));
      if (j == 1) req = 4'b1111;
      sample();
      check("lk_gnt", {28'd0, gnt}, 32'b0100);
      if (j > 0) begin
        check("lk_pio_index", {27'd0, pio_index}, 32'(j - 1));
        check("lk_pio_din", pio_din, 32'(j - 1));
      end
      step();
    end
    lock = 4'b0000;
    req = 4'b1011;
    sample();
    check("lk_after_gnt", {28'd0, gnt}, 32'b1000);
    check("lk_last_index", {27'd0, pio_index}, 32'd31);
    check("lk_last_action", {28'd0, pio_action}, 32'd1);
    step();
    req = 4'b0000;
    sample();
    check("lk_after_action", {28'd0, pio_action}, 32'd2);
    check("lk_after_din", pio_din, 32'h2003);
    step();

    // Back-to-back pulls from requesters 0 and 1.
    set_cmd(0, 4'h3, 2'd0, 5'd0, 32'd0);
    set_cmd(1, 4'h3, 2'd1, 5'd1, 32'd0);
    req = 4'b0011;
    sample();
    check("rd_gnt0", {28'd0, gnt}, 32'b0001);
    sb.push_back('{id: 0, data: 32'hA0, due: cyc + 2 + RD_LAT});
    step();
    req = 4'b0010;
    sample();
    check("rd_gnt1", {28'd0, gnt}, 32'b0010);
    sb.push_back('{id: 1, data: 32'hB1, due: cyc + 2 + RD_LAT});
    check("rd_pio_action0", {28'd0, pio_action}, 32'd3);
    check("rd_pio_index0", {27'd0, pio_index}, 32'd0);
    check("rd_rdata_idle", rdata, 32'd0);
    step();
    req = 4'b0000;
    sample();
    check("rd_pio_action1", {28'd0, pio_action}, 32'd3);
    check("rd_pio_index1", {27'd0, pio_index}, 32'd1);
    step();
    repeat (5) begin
      sample();
      step();
    end
    check("rd_drain", 32'(sb.size()), 32'd0);

    // Reset while a pull is in flight.
    set_cmd(0, 4'h3, 2'd3, 5'd2, 32'h55);
    req = 4'b0001;
    sample();
    check("rst_fl_gnt", {28'd0, gnt}, 32'b0001);
    step();
    reset = 1'b1;
    req = 4'b0000;
    sample();
    check("rst_fl_pio_action", {28'd0, pio_action}, 32'd3);
    step();
    reset = 1'b0;
    sb.delete();
    sample();
    check("rst_fl_gnt0", {28'd0, gnt}, 32'd0);
    check("rst_fl_rvalid0", {28'd0, rvalid}, 32'd0);
    check("rst_fl_rdata0", rdata, 32'd0);
    check("rst_fl_lock_err0", {28'd0, lock_err}, 32'd0);
    check("rst_fl_action0", {28'd0, pio_action}, 32'd0);
    check("rst_fl_mindex0", {30'd0, pio_mindex}, 32'd0);
    check("rst_fl_index0", {27'd0, pio_index}, 32'd0);
    check("rst_fl_din0", pio_din, 32'd0);
    step();
    for (int c = 0; c < 4; c++) begin
      sample();
      check("rst_fl_no_rvalid", {28'd0, rvalid}, 32'd0);
      step();
    end

    // Lock timeout on the MAX_LOCK=8 instance: requester 1 locks then idles.
    set_cmd(1, 4'h1, 2'd1, 5'd3, 32'h77);
    set_cmd(0, 4'h2, 2'd0, 5'd4, 32'h88);
    req = 4'b0010;
    lock = 4'b0010;
    sample();
    check("to_gnt_lock", {28'd0, gnt_to}, 32'b0010);
    step();
    req = 4'b0001;
    for (int c = 1; c < 8; c++) begin
      sample();
      check("to_locked_gnt", {28'd0, gnt_to}, 32'd0);
      check("to_locked_err", {28'd0, lock_err_to}, 32'd0);
      step();
    end
    sample();
    check("to_lock_err", {28'd0, lock_err_to}, 32'b0010);
    check("to_release_gnt", {28'd0, gnt_to}, 32'b0001);
    step();
    req = 4'b0010;
    sample();
    check("to_err_once", {28'd0, lock_err_to}, 32'd0);
    check("to_blocked_gnt", {28'd0, gnt_to}, 32'b0010);
    step();
    req = 4'b0001;
    sample();
    check("to_not_relocked", {28'd0, gnt_to}, 32'b0001);
    step();
    req = 4'b0000;
    lock = 4'b0000;
    repeat (3) step();

    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
